// File: rtl/dmem_tcm_resp.sv
// Data-memory TCM responder: req/gnt/rvalid slave with tagged word array and fixed-latency in-order responses.
// Optional error injection port err_inj_i is enabled by defining DMEM_RESP_ERR_INJ_EN.

module dmem_tcm_resp_chk #(
  parameter int unsigned CntW     = 2,
  parameter int unsigned MaxOutst = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [CntW-1:0] cnt_i,
  input  logic            rvalid_i
);

  a_cnt_max: assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_i <= CntW'(MaxOutst));
  a_cnt_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) rvalid_i |-> (cnt_i != '0));

endmodule

module dmem_tcm_resp #(
  parameter int unsigned DataW    = 33,
  parameter int unsigned Depth    = 4096,
  parameter logic [31:0] BaseAddr = 32'h8000_0000,
  parameter int unsigned RespLat  = 1,
  parameter int unsigned MaxOutst = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
`ifdef DMEM_RESP_ERR_INJ_EN
  input  logic             err_inj_i,
`endif
  input  logic             data_req_i,
  output logic             data_gnt_o,
  input  logic             data_we_i,
  input  logic [3:0]       data_be_i,
  input  logic [31:0]      data_addr_i,
  input  logic [DataW-1:0] data_wdata_i,
  output logic             data_rvalid_o,
  output logic [DataW-1:0] data_rdata_o,
  output logic             data_err_o,
  input  logic             gnt_stall_i
);

  localparam int unsigned IdxW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(MaxOutst + 1);

  logic [31:0]       mem_q [Depth];
  logic              tag_q [Depth];

  logic [CntW-1:0]   outst_cnt_q, outst_cnt_d;
  logic [RespLat-1:0] pipe_vld_q, pipe_vld_d;
  logic [RespLat-1:0] pipe_err_q, pipe_err_d;
  logic [DataW-1:0]  pipe_rdata_q [RespLat];
  logic [DataW-1:0]  pipe_rdata_d [RespLat];

  logic [31:0]       addr_off_s;
  logic [31:0]       word_off_s;
  logic [IdxW-1:0]   idx_s;
  logic              in_range_s;
  logic              inj_s;
  logic              err_s;
  logic              gnt_s;
  logic              acc_s;
  logic              wr_en_s;
  logic [DataW-1:0]  rd_word_s;

`ifdef DMEM_RESP_ERR_INJ_EN
  assign inj_s = err_inj_i;
`else
  assign inj_s = 1'b0;
`endif

  // Addresses below BaseAddr wrap to a huge offset and fail the range check.
  always_comb begin
    addr_off_s = data_addr_i - BaseAddr;
    word_off_s = addr_off_s >> 2;
    idx_s      = word_off_s[IdxW-1:0];
    in_range_s = (data_addr_i >= BaseAddr) && (word_off_s < 32'(Depth));
    gnt_s      = data_req_i & ~gnt_stall_i & (outst_cnt_q < CntW'(MaxOutst));
    err_s      = ~in_range_s | inj_s;
    acc_s      = gnt_s & ~err_s;
    wr_en_s    = acc_s & data_we_i;
    if (acc_s && !data_we_i) begin
      rd_word_s = {tag_q[idx_s], mem_q[idx_s]};
    end else begin
      rd_word_s = '0;
    end
  end

  // Array is written at the grant edge; a zero byte-enable leaves data and tag alone.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      for (int l = 0; l < 4; l++) begin
        if (data_be_i[l]) begin
          mem_q[idx_s][8*l +: 8] <= data_wdata_i[8*l +: 8];
        end
      end
      if (data_be_i == 4'hF) begin
        tag_q[idx_s] <= data_wdata_i[32];
      end else if (data_be_i != 4'h0) begin
        tag_q[idx_s] <= 1'b0;
      end
    end
  end

  always_comb begin
    pipe_vld_d = '0;
    pipe_err_d = '0;
    for (int i = 0; i < int'(RespLat); i++) begin
      pipe_rdata_d[i] = '0;
    end
    pipe_vld_d[0]   = gnt_s;
    pipe_err_d[0]   = gnt_s & err_s;
    pipe_rdata_d[0] = rd_word_s;
    for (int i = 1; i < int'(RespLat); i++) begin
      pipe_vld_d[i]   = pipe_vld_q[i-1];
      pipe_err_d[i]   = pipe_err_q[i-1];
      pipe_rdata_d[i] = pipe_rdata_q[i-1];
    end
  end

  always_comb begin
    outst_cnt_d = outst_cnt_q;
    case ({gnt_s, data_rvalid_o})
      2'b10:   outst_cnt_d = outst_cnt_q + CntW'(1);
      2'b01:   outst_cnt_d = outst_cnt_q - CntW'(1);
      default: outst_cnt_d = outst_cnt_q;
    endcase
  end

  // Reset drops any in-flight responses along with the outstanding count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outst_cnt_q <= '0;
      pipe_vld_q  <= '0;
      pipe_err_q  <= '0;
      for (int i = 0; i < int'(RespLat); i++) begin
        pipe_rdata_q[i] <= '0;
      end
    end else begin
      outst_cnt_q <= outst_cnt_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_err_q  <= pipe_err_d;
      for (int i = 0; i < int'(RespLat); i++) begin
        pipe_rdata_q[i] <= pipe_rdata_d[i];
      end
    end
  end

  assign data_gnt_o    = gnt_s;
  assign data_rvalid_o = pipe_vld_q[RespLat-1];
  assign data_err_o    = pipe_err_q[RespLat-1];
  assign data_rdata_o  = pipe_rdata_q[RespLat-1];

  dmem_tcm_resp_chk #(
    .CntW     (CntW),
    .MaxOutst (MaxOutst)
  ) u_chk (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .cnt_i    (outst_cnt_q),
    .rvalid_i (data_rvalid_o)
  );

endmodule

// File: tb/tb_dmem_tcm_resp.sv
// Scoreboard bench for dmem_tcm_resp: a default instance (RespLat=1) and a RespLat=3/MaxOutst=2 instance.
// Drivers push hand-computed responses at grant; per-instance monitors pop and compare on rvalid.

module tb_dmem_tcm_resp;

  typedef struct {
    logic [32:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic clk;
  int   cyc;
  int   checks;
  int   failures;

  exp_t q1[$];
  exp_t q3[$];
  exp_t m1;
  exp_t m3;

  logic        rst_n1, req1, we1, stall1, gnt1, rvalid1, err1, inj1;
  logic [3:0]  be1;
  logic [31:0] addr1;
  logic [32:0] wdata1, rdata1;

  logic        rst_n3, req3, we3, stall3, gnt3, rvalid3, err3, inj3;
  logic [3:0]  be3;
  logic [31:0] addr3;
  logic [32:0] wdata3, rdata3;

  dmem_tcm_resp u_dut1 (
    .clk_i         (clk),
    .rst_ni        (rst_n1),
`ifdef DMEM_RESP_ERR_INJ_EN
    .err_inj_i     (inj1),
`endif
    .data_req_i    (req1),
    .data_gnt_o    (gnt1),
    .data_we_i     (we1),
    .data_be_i     (be1),
    .data_addr_i   (addr1),
    .data_wdata_i  (wdata1),
    .data_rvalid_o (rvalid1),
    .data_rdata_o  (rdata1),
    .data_err_o    (err1),
    .gnt_stall_i   (stall1)
  );

  dmem_tcm_resp #(
    .Depth    (16),
    .RespLat  (3),
    .MaxOutst (2)
  ) u_dut3 (
    .clk_i         (clk),
    .rst_ni        (rst_n3),
`ifdef DMEM_RESP_ERR_INJ_EN
    .err_inj_i     (inj3),
`endif
    .data_req_i    (req3),
    .data_gnt_o    (gnt3),
    .data_we_i     (we3),
    .data_be_i     (be3),
    .data_addr_i   (addr3),
    .data_wdata_i  (wdata3),
    .data_rvalid_o (rvalid3),
    .data_rdata_o  (rdata3),
    .data_err_o    (err3),
    .gnt_stall_i   (stall3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitors: pop the oldest expectation on every rvalid and compare data, err and latency.
  always @(negedge clk) begin
    if (rst_n1 === 1'b1) begin
      if (q1.size() > 0 && q1[0].due < cyc) begin
        chk("d1_missing_rvalid", 64'(q1[0].due), 64'(cyc));
        void'(q1.pop_front());
      end
      if (rvalid1) begin
        if (q1.size() == 0) begin
          chk("d1_unexpected_rvalid", 64'(rvalid1), 64'd0);
        end else begin
          m1 = q1.pop_front();
          chk("d1_rdata", 64'(rdata1), 64'(m1.data));
          chk("d1_err", 64'(err1), 64'(m1.err));
          chk("d1_latency", 64'(cyc), 64'(m1.due));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n3 === 1'b1) begin
      if (q3.size() > 0 && q3[0].due < cyc) begin
        chk("d3_missing_rvalid", 64'(q3[0].due), 64'(cyc));
        void'(q3.pop_front());
      end
      if (rvalid3) begin
        if (q3.size() == 0) begin
          chk("d3_unexpected_rvalid", 64'(rvalid3), 64'd0);
        end else begin
          m3 = q3.pop_front();
          chk("d3_rdata", 64'(rdata3), 64'(m3.data));
          chk("d3_err", 64'(err3), 64'(m3.err));
          chk("d3_latency", 64'(cyc), 64'(m3.due));
        end
      end
    end
  end

  // One access on instance 1; waits (bounded) for grant and records the expected response.
  task automatic acc1(input logic we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [32:0] wd, input logic [32:0] xd, input logic xe);
    exp_t e;
    int   n;
    req1 = 1'b1; we1 = we; be1 = be; addr1 = addr; wdata1 = wd;
    n = 0;
    #1;
    while (!gnt1 && n < 8) begin
      @(negedge clk); #1; n++;
    end
    chk("d1_gnt", 64'(gnt1), 64'd1);
    if (gnt1) begin
      e.data = xd; e.err = xe; e.due = cyc + 1;
      q1.push_back(e);
    end
    @(negedge clk);
    req1 = 1'b0;
  endtask

  // Holds a request on instance 3 for n cycles and checks the grant against pat each cycle.
  task automatic hold3(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [32:0] wd, input int n, input logic [7:0] pat,
                       input logic [32:0] xd, input logic xe);
    exp_t e;
    req3 = 1'b1; we3 = we; be3 = be; addr3 = addr; wdata3 = wd;
    for (int i = 0; i < n; i++) begin
      #1;
      chk($sformatf("d3_gnt_%0d", i), 64'(gnt3), 64'(pat[i]));
      if (gnt3) begin
        e.data = xd; e.err = xe; e.due = cyc + 3;
        q3.push_back(e);
      end
      @(negedge clk);
    end
    req3 = 1'b0;
  endtask

  task automatic drain(input int which);
    int n;
    n = 0;
    while (((which == 1) ? q1.size() : q3.size()) != 0 && n < 20) begin
      @(negedge clk); n++;
    end
    chk($sformatf("d%0d_drain", which), 64'((which == 1) ? q1.size() : q3.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; checks = 0; failures = 0;
    rst_n1 = 1'b0; req1 = 1'b0; we1 = 1'b0; be1 = 4'h0; addr1 = 32'h0; wdata1 = 33'h0; stall1 = 1'b0; inj1 = 1'b0;
    rst_n3 = 1'b0; req3 = 1'b0; we3 = 1'b0; be3 = 4'h0; addr3 = 32'h0; wdata3 = 33'h0; stall3 = 1'b0; inj3 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_gnt1", 64'(gnt1), 64'd0);
    chk("rst_rvalid1", 64'(rvalid1), 64'd0);
    chk("rst_err1", 64'(err1), 64'd0);
    chk("rst_rdata1", 64'(rdata1), 64'd0);
    chk("rst_rvalid3", 64'(rvalid3), 64'd0);
    chk("rst_rdata3", 64'(rdata3), 64'd0);
    @(negedge clk);
    rst_n1 = 1'b1; rst_n3 = 1'b1;
    @(negedge clk);

    // Instance 1: write/read with tag, partial write, out-of-range, RAW, zero byte-enable.
    acc1(1'b1, 4'hF, 32'h8000_0010, {1'b1, 32'hDEAD_BEEF}, 33'h0, 1'b0);
    acc1(1'b0, 4'hF, 32'h8000_0010, 33'h0, {1'b1, 32'hDEAD_BEEF}, 1'b0);
    acc1(1'b1, 4'h3, 32'h8000_0010, {1'b1, 32'h0000_1234}, 33'h0, 1'b0);
    acc1(1'b0, 4'hF, 32'h8000_0010, 33'h0, {1'b0, 32'hDEAD_1234}, 1'b0);
    acc1(1'b0, 4'hF, 32'h7FFF_FFFC, 33'h0, 33'h0, 1'b1);
    acc1(1'b0, 4'hF, 32'h8000_4000, 33'h0, 33'h0, 1'b1);
    acc1(1'b1, 4'hF, 32'h8000_4010, {1'b1, 32'hFFFF_FFFF}, 33'h0, 1'b1);
    acc1(1'b0, 4'hF, 32'h8000_0010, 33'h0, {1'b0, 32'hDEAD_1234}, 1'b0);
    acc1(1'b1, 4'hF, 32'h8000_0020, {1'b1, 32'hAAAA_5555}, 33'h0, 1'b0);
    acc1(1'b1, 4'hF, 32'h8000_0020, {1'b0, 32'h1111_2222}, 33'h0, 1'b0);
    acc1(1'b0, 4'hF, 32'h8000_0020, 33'h0, {1'b0, 32'h1111_2222}, 1'b0);
    acc1(1'b1, 4'h0, 32'h8000_0020, {1'b1, 32'h9999_9999}, 33'h0, 1'b0);
    acc1(1'b0, 4'hF, 32'h8000_0020, 33'h0, {1'b0, 32'h1111_2222}, 1'b0);
    acc1(1'b1, 4'hF, 32'h8000_3FFC, {1'b1, 32'h0BAD_CAFE}, 33'h0, 1'b0);
    acc1(1'b0, 4'hF, 32'h8000_3FFC, 33'h0, {1'b1, 32'h0BAD_CAFE}, 1'b0);
`ifdef DMEM_RESP_ERR_INJ_EN
    inj1 = 1'b1;
    acc1(1'b1, 4'hF, 32'h8000_0010, {1'b1, 32'hFFFF_FFFF}, 33'h0, 1'b1);
    acc1(1'b0, 4'hF, 32'h8000_0010, 33'h0, 33'h0, 1'b1);
    inj1 = 1'b0;
    acc1(1'b0, 4'hF, 32'h8000_0010, 33'h0, {1'b0, 32'hDEAD_1234}, 1'b0);
`endif
    drain(1);

    // Instance 3: outstanding limit, back-pressure, range boundary, reset with responses in flight.
    hold3(1'b1, 4'hF, 32'h8000_0008, {1'b1, 32'hCAFE_F00D}, 1, 8'h01, 33'h0, 1'b0);
    drain(3);
    hold3(1'b0, 4'hF, 32'h8000_0008, 33'h0, 6, 8'b0011_0011, {1'b1, 32'hCAFE_F00D}, 1'b0);
    stall3 = 1'b1;
    hold3(1'b0, 4'hF, 32'h8000_0008, 33'h0, 5, 8'h00, {1'b1, 32'hCAFE_F00D}, 1'b0);
    stall3 = 1'b0;
    hold3(1'b0, 4'hF, 32'h8000_0008, 33'h0, 1, 8'h01, {1'b1, 32'hCAFE_F00D}, 1'b0);
    drain(3);
    hold3(1'b0, 4'hF, 32'h8000_0040, 33'h0, 1, 8'h01, 33'h0, 1'b1);
    drain(3);
    hold3(1'b1, 4'hF, 32'h8000_000C, {1'b0, 32'h1234_5678}, 1, 8'h01, 33'h0, 1'b0);
    drain(3);
    hold3(1'b0, 4'hF, 32'h8000_0008, 33'h0, 2, 8'h03, {1'b1, 32'hCAFE_F00D}, 1'b0);
    rst_n3 = 1'b0;
    q3.delete();
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("d3_rst_rvalid", 64'(rvalid3), 64'd0);
      chk("d3_rst_rdata", 64'(rdata3), 64'd0);
      @(negedge clk);
    end
    rst_n3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("d3_post_rst_rvalid", 64'(rvalid3), 64'd0);
      @(negedge clk);
    end
    hold3(1'b0, 4'hF, 32'h8000_000C, 33'h0, 3, 8'h03, {1'b0, 32'h1234_5678}, 1'b0);
    drain(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
